// File: rtl/sb_packet_encoder_v2.sv
// Sideband packet encoder: sends a training pattern on request, then TAIL_ITER
// tail words, otherwise drains a small packet FIFO toward the serializer.
module sb_packet_encoder_v2 #(
  parameter int                 DATA_W         = 64,
  parameter logic [DATA_W-1:0]  PATTERN        = {DATA_W/2{2'b10}},
  parameter int                 TAIL_ITER      = 4,
  parameter int                 FIFO_DEPTH     = 4,
  parameter int                 TIMEOUT_CYCLES = 8000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start_pattern_req,
  input  logic                          i_rx_sb_pattern_samp_done,
  input  logic                          i_ser_done,
  input  logic                          i_packet_valid,
  input  logic [DATA_W-1:0]             i_packet,
  output logic                          o_packet_ready,
  input  logic                          i_timeout_ctr_start,
  input  logic                          i_stop_cnt,
  input  logic                          i_rx_sb_rsp_delivered,
  output logic                          o_start_pattern_done,
  output logic                          o_time_out,
  output logic                          o_valid,
  output logic [DATA_W-1:0]             o_final_packet,
  output logic                          o_pattern_active,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TL_W  = $clog2(TAIL_ITER + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  // IDLE: drain FIFO | PATTERN: pattern until samp_done | TAIL: TAIL_ITER words | DONE: done pulse
  typedef enum logic [1:0] {ST_IDLE, ST_PATTERN, ST_TAIL, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_samp_pend;
  logic              r_pat_entry;
  logic [TL_W-1:0]   r_tail_cnt;

  logic              r_to_armed;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_time_out;
  logic              w_to_arm;
  logic              w_to_disarm;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start_pattern_req) w_next_state = ST_PATTERN;
      end
      ST_PATTERN: begin
        if (r_time_out) w_next_state = ST_IDLE;
        else if (i_rx_sb_pattern_samp_done || r_samp_pend) w_next_state = ST_TAIL;
      end
      ST_TAIL: begin
        if (r_time_out) w_next_state = ST_IDLE;
        else if (i_ser_done && (r_tail_cnt == TL_W'(TAIL_ITER - 1))) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_samp_pend <= 1'b0;
      r_pat_entry <= 1'b0;
      r_tail_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      // samp_done seen on the IDLE->PATTERN cycle is remembered for one cycle
      r_samp_pend <= (r_state == ST_IDLE) && i_start_pattern_req && i_rx_sb_pattern_samp_done;
      r_pat_entry <= (r_state == ST_IDLE) && i_start_pattern_req;
      if (r_state == ST_PATTERN)
        r_tail_cnt <= '0;
      else if ((r_state == ST_TAIL) && i_ser_done)
        r_tail_cnt <= r_tail_cnt + TL_W'(1);
    end
  end

  assign w_to_arm    = i_timeout_ctr_start || r_pat_entry;
  assign w_to_disarm = i_stop_cnt || i_rx_sb_rsp_delivered || (r_state == ST_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_armed <= 1'b0;
      r_to_cnt   <= '0;
      r_time_out <= 1'b0;
    end else begin
      r_time_out <= 1'b0;
      if (w_to_disarm) begin
        r_to_armed <= 1'b0;
        r_to_cnt   <= '0;
      end else if (w_to_arm) begin
        r_to_armed <= 1'b1;
        r_to_cnt   <= '0;
      end else if (r_to_armed) begin
        // registered pulse lands TIMEOUT_CYCLES cycles after the arming cycle
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 2)) begin
          r_to_armed <= 1'b0;
          r_to_cnt   <= '0;
          r_time_out <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = i_packet_valid && !w_full;
  assign w_pop   = (r_state == ST_IDLE) && !w_empty && i_ser_done;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_packet;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    o_valid              = 1'b0;
    o_final_packet       = '0;
    o_pattern_active     = 1'b0;
    o_start_pattern_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_valid = !w_empty;
        if (!w_empty) o_final_packet = r_mem[r_rd_ptr];
      end
      ST_PATTERN, ST_TAIL: begin
        o_valid          = 1'b1;
        o_final_packet   = PATTERN;
        o_pattern_active = 1'b1;
      end
      ST_DONE: o_start_pattern_done = 1'b1;
      default: o_valid = 1'b0;
    endcase
  end

  assign o_time_out     = r_time_out;
  assign o_packet_ready = !w_full;
  assign o_fifo_level   = r_level;

endmodule

// File: tb/tb_sb_packet_encoder_v2.sv
// Bench for sb_packet_encoder_v2: directed scenarios plus random traffic, every
// cycle compared against a queue/deadline reference model.
module tb_sb_packet_encoder_v2;

  localparam int          DW    = 64;
  localparam int          TAILN = 4;
  localparam int          DEPTH = 4;
  localparam int          TO    = 16;
  localparam logic [63:0] PAT   = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam int M_IDLE = 0;
  localparam int M_PAT  = 1;
  localparam int M_TAIL = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0, samp = 1'b0, ser = 1'b0, pv = 1'b0;
  logic [DW-1:0] pkt = '0;
  logic          tstart = 1'b0, stop = 1'b0, deliv = 1'b0;
  logic          o_packet_ready, o_start_pattern_done, o_time_out, o_valid, o_pattern_active;
  logic [DW-1:0] o_final_packet;
  logic [2:0]    o_fifo_level;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_q[$];
  int m_mode = M_IDLE;
  int m_tails = 0;
  int m_deadline = -1;
  int m_cyc = 0;
  bit m_first_pat = 0;
  bit m_pend = 0;

  int n_done = 0;
  int n_to = 0;
  int last_to_cyc = -1;
  logic [DW-1:0] words [5];

  sb_packet_encoder_v2 #(
    .DATA_W(DW), .TAIL_ITER(TAILN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_start_pattern_req(req), .i_rx_sb_pattern_samp_done(samp), .i_ser_done(ser),
    .i_packet_valid(pv), .i_packet(pkt), .o_packet_ready(o_packet_ready),
    .i_timeout_ctr_start(tstart), .i_stop_cnt(stop), .i_rx_sb_rsp_delivered(deliv),
    .o_start_pattern_done(o_start_pattern_done), .o_time_out(o_time_out),
    .o_valid(o_valid), .o_final_packet(o_final_packet),
    .o_pattern_active(o_pattern_active), .o_fifo_level(o_fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE;
    m_tails = 0;
    m_deadline = -1;
    m_first_pat = 0;
    m_pend = 0;
  endtask

  // One clock cycle: compare outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    int qs;
    bit e_act, e_valid, e_to, pop, push, arm, disarm;
    logic [63:0] e_data;
    @(negedge clk);
    qs = m_q.size();
    e_act = (m_mode == M_PAT) || (m_mode == M_TAIL);
    e_valid = e_act || ((m_mode == M_IDLE) && (qs > 0));
    e_data = '0;
    if (e_act) e_data = PAT;
    else if ((m_mode == M_IDLE) && (qs > 0)) e_data = m_q[0];
    e_to = (m_deadline == m_cyc);
    chk("valid", 64'(o_valid), 64'(e_valid));
    chk("final_packet", o_final_packet, e_data);
    chk("pattern_active", 64'(o_pattern_active), 64'(e_act));
    chk("start_pattern_done", 64'(o_start_pattern_done), 64'(m_mode == M_DONE));
    chk("time_out", 64'(o_time_out), 64'(e_to));
    chk("packet_ready", 64'(o_packet_ready), 64'(qs < DEPTH));
    chk("fifo_level", 64'(o_fifo_level), 64'(qs));
    if (o_start_pattern_done) n_done++;
    if (o_time_out) begin
      n_to++;
      last_to_cyc = m_cyc;
    end
    pop = (m_mode == M_IDLE) && (qs > 0) && ser;
    push = pv && (qs < DEPTH);
    if (pop) m_q.delete(0);
    if (push) m_q.push_back(pkt);
    disarm = stop || deliv || (m_mode == M_DONE);
    arm = tstart || m_first_pat;
    if (disarm) m_deadline = -1;
    else if (arm) m_deadline = m_cyc + TO;
    m_first_pat = 0;
    case (m_mode)
      M_IDLE: if (req) begin
        m_mode = M_PAT;
        m_first_pat = 1;
        m_pend = samp;
      end
      M_PAT: begin
        if (e_to) m_mode = M_IDLE;
        else if (samp || m_pend) begin
          m_mode = M_TAIL;
          m_tails = 0;
        end
        m_pend = 0;
      end
      M_TAIL: begin
        if (e_to) m_mode = M_IDLE;
        else if (ser) begin
          m_tails++;
          if (m_tails == TAILN) m_mode = M_DONE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_final_packet", o_final_packet, 64'd0);
    chk("rst_done", 64'(o_start_pattern_done), 64'd0);
    chk("rst_time_out", 64'(o_time_out), 64'd0);
    chk("rst_active", 64'(o_pattern_active), 64'd0);
    chk("rst_level", 64'(o_fifo_level), 64'd0);
    chk("rst_ready", 64'(o_packet_ready), 64'd1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    // Pattern handshake: samp_done on the fifth pattern cycle, then four tail words.
    n_done = 0; n_to = 0;
    req = 1; tick(); req = 0;
    repeat (4) begin ser = 1'($urandom_range(0, 1)); tick(); end
    ser = 0; samp = 1; tick(); samp = 0;
    chk("s1_tail_word", o_final_packet, PAT);
    ser = 1; repeat (TAILN) tick(); ser = 0;
    tick(); tick();
    chk("s1_done_count", 64'(n_done), 64'd1);
    chk("s1_timeout_count", 64'(n_to), 64'd0);

    // samp_done coinciding with the IDLE->PATTERN transition.
    n_done = 0;
    req = 1; samp = 1; tick(); req = 0; samp = 0;
    ser = 1; repeat (TAILN + 1) tick(); ser = 0;
    tick(); tick();
    chk("s1b_done_count", 64'(n_done), 64'd1);

    // Pattern timeout with no samp_done.
    n_done = 0; n_to = 0;
    c0 = m_cyc;
    req = 1; tick(); req = 0;
    repeat (19) tick();
    chk("s2_timeout_count", 64'(n_to), 64'd1);
    chk("s2_timeout_cycle", 64'(last_to_cyc), 64'(c0 + 1 + TO));
    chk("s2_done_count", 64'(n_done), 64'd0);
    chk("s2_idle_after", 64'(o_pattern_active), 64'd0);

    // Fill past capacity, then drain in order.
    pv = 1;
    for (int i = 0; i < 5; i++) begin
      words[i] = {$urandom, $urandom};
      pkt = words[i];
      tick();
    end
    pv = 0;
    chk("s3_level_full", 64'(o_fifo_level), 64'd4);
    chk("s3_ready_full", 64'(o_packet_ready), 64'd0);
    ser = 1;
    for (int i = 0; i < 4; i++) begin
      chk("s3_pop_order", o_final_packet, words[i]);
      tick();
    end
    ser = 0;
    chk("s3_level_empty", 64'(o_fifo_level), 64'd0);

    // Packets buffered across a pattern sequence.
    n_done = 0;
    pv = 1;
    for (int i = 0; i < 2; i++) begin
      words[i] = {$urandom, $urandom};
      pkt = words[i];
      tick();
    end
    pv = 0;
    req = 1; tick(); req = 0;
    ser = 1; repeat (3) tick();
    chk("s4_level_held", 64'(o_fifo_level), 64'd2);
    chk("s4_pattern_shown", o_final_packet, PAT);
    samp = 1; tick(); samp = 0;
    repeat (TAILN) tick();
    tick();
    chk("s4_done_count", 64'(n_done), 64'd1);
    chk("s4_first_out", o_final_packet, words[0]);
    tick();
    chk("s4_second_out", o_final_packet, words[1]);
    tick();
    ser = 0;
    chk("s4_level_empty", 64'(o_fifo_level), 64'd0);

    // Timeout counter controls: disarm beats start, restart, delivered disarms.
    n_to = 0;
    tstart = 1; stop = 1; tick(); tstart = 0; stop = 0;
    repeat (20) tick();
    chk("s5_no_timeout_after_stop", 64'(n_to), 64'd0);
    c0 = m_cyc;
    tstart = 1; tick(); tstart = 0;
    repeat (9) tick();
    tstart = 1; tick(); tstart = 0;
    repeat (20) tick();
    chk("s5_restart_count", 64'(n_to), 64'd1);
    chk("s5_restart_cycle", 64'(last_to_cyc), 64'(c0 + 10 + TO));
    tstart = 1; tick(); tstart = 0;
    repeat (5) tick();
    deliv = 1; tick(); deliv = 0;
    repeat (20) tick();
    chk("s5_delivered_disarm", 64'(n_to), 64'd1);

    // Reset asserted in TAIL with three packets buffered.
    pv = 1;
    repeat (3) begin pkt = {$urandom, $urandom}; tick(); end
    pv = 0;
    req = 1; tick(); req = 0;
    samp = 1; tick(); samp = 0;
    ser = 1; repeat (2) tick(); ser = 0;
    chk("s6_level_before", 64'(o_fifo_level), 64'd3);
    chk("s6_active_before", 64'(o_pattern_active), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_valid", 64'(o_valid), 64'd0);
    chk("s6_rst_final_packet", o_final_packet, 64'd0);
    chk("s6_rst_active", 64'(o_pattern_active), 64'd0);
    chk("s6_rst_level", 64'(o_fifo_level), 64'd0);
    chk("s6_rst_ready", 64'(o_packet_ready), 64'd1);
    chk("s6_rst_done", 64'(o_start_pattern_done), 64'd0);
    chk("s6_rst_time_out", 64'(o_time_out), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    n_done = 0; n_to = 0;
    repeat (20) tick();
    chk("s6_no_done_after_rst", 64'(n_done), 64'd0);
    chk("s6_no_timeout_after_rst", 64'(n_to), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      req    = ($urandom_range(0, 9) == 0);
      samp   = ($urandom_range(0, 3) == 0);
      ser    = 1'($urandom_range(0, 1));
      pv     = 1'($urandom_range(0, 1));
      pkt    = {$urandom, $urandom};
      tstart = ($urandom_range(0, 15) == 0);
      stop   = ($urandom_range(0, 19) == 0);
      deliv  = ($urandom_range(0, 24) == 0);
      tick();
    end
    req = 0; samp = 0; ser = 0; pv = 0; tstart = 0; stop = 0; deliv = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
